// File: rtl/imm_compress.sv
// Immediate compressor: narrows signed operands to 3/6/8-bit fields, flags
// values that do not survive sign-extension, and queues results in a small FIFO.
module imm_compress #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [1:0]       in_len_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_field,
    output logic [1:0]       out_len_sel,
    output logic             out_ovf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = 11;

    logic [7:0]       enc_field;
    logic             enc_ovf;
    logic [ENT_W-1:0] entry;
    logic [ENT_W-1:0] head_n;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr_n;
    logic [PTR_W-1:0] rptr_n;
    logic [OCC_W-1:0] count;
    logic [OCC_W-1:0] count_n;
    logic             accept;
    logic             pop;

    // Narrowing: a field is exact only if the dropped bits replicate its sign bit
    always_comb begin
        enc_field = in_data;
        enc_ovf   = 1'b0;
        case (in_len_sel)
            2'b10: begin
                enc_field = {5'b0, in_data[2:0]};
                enc_ovf   = !((&in_data[7:2]) || !(|in_data[7:2]));
            end
            2'b11: begin
                enc_field = {2'b0, in_data[5:0]};
                enc_ovf   = !((&in_data[7:5]) || !(|in_data[7:5]));
            end
            default: begin
                enc_field = in_data;
                enc_ovf   = 1'b0;
            end
        endcase
    end

    assign entry   = {enc_field, in_len_sel, enc_ovf};
    assign accept  = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign wptr_n  = wptr + PTR_W'(accept);
    assign rptr_n  = rptr + PTR_W'(pop);
    assign count_n = count + OCC_W'(accept) - OCC_W'(pop);

    // Next head: the entry being written this edge if it lands at the new read slot
    assign head_n = (accept && (wptr == rptr_n)) ? entry : mem[rptr_n];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_field   <= '0;
            out_len_sel <= '0;
            out_ovf     <= 1'b0;
        end else begin
            wptr        <= wptr_n;
            rptr        <= rptr_n;
            count       <= count_n;
            in_ready    <= (count_n != OCC_W'(DEPTH));
            out_valid   <= (count_n != '0);
            out_field   <= head_n[10:3];
            out_len_sel <= head_n[2:1];
            out_ovf     <= head_n[0];
        end
    end

    // Saturating overflow counter; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clr_cnt) begin
            ovf_cnt <= '0;
        end else if (accept && enc_ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_compress.sv
// Directed bench for imm_compress: encoding, FIFO ordering/backpressure,
// counter saturation and clear, and mid-operation reset.
module tb_imm_compress;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_len_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_field;
    logic [1:0] out_len_sel;
    logic       out_ovf;
    logic       clr_cnt;
    logic [7:0] ovf_cnt;

    int vec_cnt;
    int err_cnt;

    imm_compress #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len_sel (in_len_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_field  (out_field),
        .out_len_sel(out_len_sel),
        .out_ovf    (out_ovf),
        .clr_cnt    (clr_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single accept with out_ready=1; head must appear right after the edge
    task automatic single(input logic [7:0] d, input logic [1:0] l,
                          input logic [7:0] f, input logic o, input string tag);
        in_valid = 1'b1; in_data = d; in_len_sel = l;
        check({tag, "_rdy"}, int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check({tag, "_vld"}, int'(out_valid), 1);
        check({tag, "_fld"}, int'(out_field), int'(f));
        check({tag, "_len"}, int'(out_len_sel), int'(l));
        check({tag, "_ovf"}, int'(out_ovf), int'(o));
        step();
        check({tag, "_empty"}, int'(out_valid), 0);
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len_sel = '0;
        out_ready = 1'b0; clr_cnt = 1'b0;

        #2;
        check("rst_rdy", int'(in_ready), 0);
        check("rst_vld", int'(out_valid), 0);
        check("rst_fld", int'(out_field), 0);
        check("rst_cnt", int'(ovf_cnt), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_rdy", int'(in_ready), 1);

        // Single values
        out_ready = 1'b1;
        single(8'hFD, 2'b10, 8'h05, 1'b0, "fd3");
        single(8'h04, 2'b10, 8'h04, 1'b1, "043");
        check("cnt1", int'(ovf_cnt), 1);
        single(8'hE0, 2'b11, 8'h20, 1'b0, "e06");
        single(8'h40, 2'b11, 8'h00, 1'b1, "406");
        single(8'h9C, 2'b00, 8'h9C, 1'b0, "9c8");
        check("cnt2", int'(ovf_cnt), 2);

        // Fill to full with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_len_sel = 2'b01;
            step();
        end
        in_valid = 1'b0;
        check("full_rdy", int'(in_ready), 0);
        check("full_head", int'(out_field), 8'h01);
        step();
        check("full_hold", int'(out_field), 8'h01);
        check("full_rdy2", int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop1_rdy", int'(in_ready), 1);
        check("pop1_head", int'(out_field), 8'h02);
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            check("drain_vld", int'(out_valid), 1);
            check("drain_fld", int'(out_field), i);
            step();
        end
        check("drain_empty", int'(out_valid), 0);
        single(8'h05, 2'b01, 8'h05, 1'b0, "wrap");

        // Steady push/pop with a two-entry lag
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i); in_len_sel = 2'b00;
            if (i >= 2) begin
                out_ready = 1'b1;
                check("lag_fld", int'(out_field), 8'h10 + i - 2);
                check("lag_rdy", int'(in_ready), 1);
            end
            step();
        end
        in_valid = 1'b0;
        check("lag_d0", int'(out_field), 8'h18);
        step();
        check("lag_d1", int'(out_field), 8'h19);
        step();
        check("lag_empty", int'(out_valid), 0);

        // Counter saturation and clear priority
        in_valid = 1'b1; in_data = 8'h7F; in_len_sel = 2'b10;
        for (int i = 0; i < 100; i++) step();
        check("cnt_102", int'(ovf_cnt), 102);
        for (int i = 0; i < 200; i++) step();
        check("cnt_sat", int'(ovf_cnt), 255);
        check("sat_ovf", int'(out_ovf), 1);
        check("sat_fld", int'(out_field), 8'h07);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt_clr", int'(ovf_cnt), 0);
        step();
        in_valid = 1'b0;
        check("cnt_after", int'(ovf_cnt), 1);
        step();
        step();
        check("cnt_empty", int'(out_valid), 0);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i); in_len_sel = 2'b11;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_vld", int'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", int'(out_valid), 0);
        check("mid_rst_cnt", int'(ovf_cnt), 0);
        check("mid_rst_rdy", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst_rdy", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            check("no_stale", int'(out_valid), 0);
            step();
        end
        single(8'hA5, 2'b00, 8'hA5, 1'b0, "post");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
